// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the I/D memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arbState_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } reqId_e;

  localparam int LINE_W_DEF  = 128;
  localparam int ADDR_W_DEF  = 32;
  localparam int MEM_LAT_DEF = 5;
  // Wide enough for the largest legal latency (15).
  localparam int CNT_W       = 4;

endpackage

// File: rtl/mem_lat_counter.sv
// Down-counter timing the fixed memory latency; saturates at zero.
module mem_lat_counter
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] count_r;

  // Load wins over decrement; holding at zero keeps a late decrement harmless.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= loadVal;
    end else if (dec && (count_r != 4'd0)) begin
      count_r <= count_r - 4'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == 4'd0);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (I-cache / D-cache) line arbiter in front of a fixed-latency memory.
// Define MEM_ARB_RR_EN for round-robin on collisions; otherwise D has fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEF,
  parameter int LINE_W  = LINE_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy
);

  arbState_e         state_r;
  reqId_e            winId_r;
  logic [ADDR_W-1:0] latAddr_r;
  logic              latWe_r;
  logic [LINE_W-1:0] latWdata_r;
  logic [LINE_W-1:0] iRdata_r;
  logic [LINE_W-1:0] dRdata_r;
  logic              iAck_r;
  logic              dAck_r;
  logic              memReq_r;
  logic              memWe_r;
  logic              busy_r;

  logic              anyReq_s;
  reqId_e            pick_s;
  logic              cntLoad_s;
  logic              cntDec_s;
  logic              cntZero_s;
  logic [CNT_W-1:0]  cntCount_s;
  logic              unusedBits_s;

  assign anyReq_s = i_req | d_req;

`ifdef MEM_ARB_RR_EN
  reqId_e lastGrant_r;

  // On a tie the side that did not win last time gets the grant.
  always_comb begin
    pick_s = REQ_D;
    if (i_req && d_req) begin
      pick_s = (lastGrant_r == REQ_D) ? REQ_I : REQ_D;
    end else if (i_req) begin
      pick_s = REQ_I;
    end else begin
      pick_s = REQ_D;
    end
  end

  // Reset value REQ_I makes the first collision go to D.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lastGrant_r <= REQ_I;
    end else if ((state_r == IDLE) && anyReq_s) begin
      lastGrant_r <= pick_s;
    end else begin
      lastGrant_r <= lastGrant_r;
    end
  end
`else
  // Fixed priority: the data side always wins a collision.
  always_comb begin
    pick_s = REQ_D;
    if (d_req) begin
      pick_s = REQ_D;
    end else if (i_req) begin
      pick_s = REQ_I;
    end else begin
      pick_s = REQ_D;
    end
  end
`endif

  assign cntLoad_s = (state_r == ISSUE);
  assign cntDec_s  = (state_r == WAIT);

  mem_lat_counter u_lat (
    .clk    (clk),
    .reset  (reset),
    .load   (cntLoad_s),
    .loadVal(CNT_W'(MEM_LAT - 1)),
    .dec    (cntDec_s),
    .count  (cntCount_s),
    .zero   (cntZero_s)
  );

  // Control FSM; strobes default low so each one lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= IDLE;
      winId_r    <= REQ_I;
      latAddr_r  <= '0;
      latWe_r    <= 1'b0;
      latWdata_r <= '0;
      iRdata_r   <= '0;
      dRdata_r   <= '0;
      iAck_r     <= 1'b0;
      dAck_r     <= 1'b0;
      memReq_r   <= 1'b0;
      memWe_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      iAck_r   <= 1'b0;
      dAck_r   <= 1'b0;
      memReq_r <= 1'b0;
      memWe_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (anyReq_s) begin
            winId_r    <= pick_s;
            latAddr_r  <= (pick_s == REQ_I) ? i_addr : d_addr;
            latWe_r    <= (pick_s == REQ_D) && d_we;
            latWdata_r <= (pick_s == REQ_D) ? d_wdata : '0;
            memReq_r   <= 1'b1;
            memWe_r    <= (pick_s == REQ_D) && d_we;
            busy_r     <= 1'b1;
            state_r    <= ISSUE;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        ISSUE: state_r <= WAIT;
        WAIT: begin
          if (cntZero_s) begin
            // Memory data is valid in exactly this cycle; writes leave rdata alone.
            if (!latWe_r) begin
              if (winId_r == REQ_I) iRdata_r <= mem_rdata;
              else                  dRdata_r <= mem_rdata;
            end
            iAck_r  <= (winId_r == REQ_I);
            dAck_r  <= (winId_r == REQ_D);
            state_r <= RESP;
          end
        end
        RESP: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign i_ack     = iAck_r;
  assign d_ack     = dAck_r;
  assign i_rdata   = iRdata_r;
  assign d_rdata   = dRdata_r;
  assign mem_req   = memReq_r;
  assign mem_we    = memWe_r;
  assign mem_addr  = {latAddr_r[ADDR_W-1:4], 4'b0000};
  assign mem_wdata = latWdata_r;
  assign busy      = busy_r;

  // Byte offset and the raw count are not needed by the datapath.
  assign unusedBits_s = ^{cntCount_s, latAddr_r[3:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with MEM_LAT=5 and MEM_LAT=1 instances, checked
// against a transaction-timing model; honours MEM_ARB_RR_EN like the design.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int LW   = 128;
  localparam int AW   = 32;
  localparam int NCYC = 700;

  int   testCnt = 0;
  int   failCnt = 0;
  int   doneCnt = 0;
  logic clk     = 1'b0;

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    testCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int LAT = (gi == 0) ? 5 : 1;

    logic          reset, i_req, i_ack, d_req, d_we, d_ack, mem_req, mem_we, busy;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [LW-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
    logic [LW-1:0] memModel [logic [AW-1:0]];

    mem_arbiter #(.MEM_LAT(LAT), .LINE_W(LW), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    function automatic logic [LW-1:0] rdLine(input logic [AW-1:0] a);
      if (memModel.exists(a)) return memModel[a];
      return {4{a ^ 32'h5A5A_0000}};
    endfunction

    function automatic string tg(input string s, input int n);
      return $sformatf("L%0d n%0d %s", LAT, n, s);
    endfunction

    // Cycle n is the period after rising edge n; inputs set in iteration n are taken at edge n+1.
    // A grant taken at edge g gives ISSUE in cycle g and the ack in cycle g+LAT+1.
    initial begin
      bit            active, pendI, pendD, tWe, rstTest;
      int            g, dirStep, quietUntil, rstRel;
      reqId_e        win, lastWin;
      logic [AW-1:0] tAddr, alAddr;
      logic [LW-1:0] tWdata, expI, expD;
      logic          expBusy, expIAck, expDAck, expMemReq;

      reset = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
      active = 1'b0; pendI = 1'b0; pendD = 1'b0; tWe = 1'b0; rstTest = 1'b0;
      g = 0; dirStep = 0; quietUntil = 0; rstRel = -1;
      win = REQ_I; lastWin = REQ_I; tAddr = '0; tWdata = '0; expI = '0; expD = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkVal(tg("rst_busy", -1), LW'(busy), '0);
      checkVal(tg("rst_i_ack", -1), LW'(i_ack), '0);
      checkVal(tg("rst_d_ack", -1), LW'(d_ack), '0);
      checkVal(tg("rst_mem_req", -1), LW'(mem_req), '0);
      checkVal(tg("rst_mem_we", -1), LW'(mem_we), '0);
      checkVal(tg("rst_i_rdata", -1), i_rdata, '0);
      checkVal(tg("rst_d_rdata", -1), d_rdata, '0);
      reset = 1'b1;

      for (int n = 0; n < NCYC; n++) begin
        if (active && n >= g + LAT + 2) active = 1'b0;
        if (n == rstRel) reset = 1'b1;
        alAddr = {tAddr[AW-1:4], 4'b0000};
        if (active && n == g + LAT + 1 && !tWe) begin
          if (win == REQ_I) expI = rdLine(alAddr);
          else              expD = rdLine(alAddr);
        end

        expMemReq = active && (n == g);
        expBusy   = active && (n >= g) && (n <= g + LAT + 1);
        expIAck   = active && (n == g + LAT + 1) && (win == REQ_I);
        expDAck   = active && (n == g + LAT + 1) && (win == REQ_D);
        checkVal(tg("busy", n), LW'(busy), LW'(expBusy));
        checkVal(tg("i_ack", n), LW'(i_ack), LW'(expIAck));
        checkVal(tg("d_ack", n), LW'(d_ack), LW'(expDAck));
        checkVal(tg("mem_req", n), LW'(mem_req), LW'(expMemReq));
        checkVal(tg("i_rdata", n), i_rdata, expI);
        checkVal(tg("d_rdata", n), d_rdata, expD);
        if (expMemReq) begin
          checkVal(tg("mem_addr", n), LW'(mem_addr), LW'(alAddr));
          checkVal(tg("mem_we", n), LW'(mem_we), LW'(tWe));
          if (tWe) checkVal(tg("mem_wdata", n), mem_wdata, tWdata);
        end

        // Memory returns data only in the last WAIT cycle; anything else is noise.
        if (active && !tWe && n == g + LAT) mem_rdata = rdLine(alAddr);
        else                                mem_rdata = {$urandom, $urandom, $urandom, $urandom};

        if (active && rstTest && n == g + LAT - 2) begin
          reset = 1'b0; rstRel = n + 1; rstTest = 1'b0;
          active = 1'b0; pendI = 1'b0; pendD = 1'b0; i_req = 1'b0; d_req = 1'b0;
          expI = '0; expD = '0; lastWin = REQ_I; quietUntil = n + 12;
        end

        if (active && n >= g && n <= g + LAT && $urandom_range(0, 15) == 0) begin
          if (win == REQ_I) i_req = 1'b0;
          else              d_req = 1'b0;
        end

        if (n >= quietUntil) begin
          if (dirStep < 5) begin
            if (!active && !pendI && !pendD) begin
              case (dirStep)
                0, 1: begin
                  pendI = 1'b1; i_req = 1'b1; i_addr = $urandom;
                  pendD = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = $urandom;
                end
                2: begin
                  memModel[32'h0000_1230] = {16{8'hA5}};
                  pendI = 1'b1; i_req = 1'b1; i_addr = 32'h0000_1234;
                end
                3: begin
                  pendD = 1'b1; d_req = 1'b1; d_we = 1'b1;
                  d_addr = 32'h0000_0040; d_wdata = {8{16'hDEAD}};
                end
                default: begin
                  if (LAT >= 3) begin
                    pendI = 1'b1; i_req = 1'b1; i_addr = $urandom; rstTest = 1'b1;
                  end
                end
              endcase
              dirStep++;
            end
          end else begin
            if (!pendI && $urandom_range(0, 3) == 0) begin
              pendI = 1'b1; i_req = 1'b1; i_addr = $urandom;
            end
            if (!pendD && $urandom_range(0, 3) == 0) begin
              pendD = 1'b1; d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
              d_addr = $urandom; d_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
          end
        end

        // The acked requester lets go in the following cycle.
        if (active && n == g + LAT + 1) begin
          if (win == REQ_I) begin i_req = 1'b0; pendI = 1'b0; end
          else              begin d_req = 1'b0; pendD = 1'b0; end
        end

        if (!active && reset && (i_req || d_req)) begin
          if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
            win = (lastWin == REQ_D) ? REQ_I : REQ_D;
`else
            win = REQ_D;
`endif
          end else begin
            win = i_req ? REQ_I : REQ_D;
          end
          lastWin = win;
          active  = 1'b1;
          g       = n + 1;
          tAddr   = (win == REQ_I) ? i_addr : d_addr;
          tWe     = (win == REQ_D) && d_we;
          tWdata  = d_wdata;
          if (tWe) memModel[{tAddr[AW-1:4], 4'b0000}] = tWdata;
        end

        @(negedge clk);
      end
      doneCnt++;
    end
  end

  initial begin
    for (int k = 0; k < NCYC + 200 && doneCnt < 2; k++) @(posedge clk);
    checkVal("all_done", LW'(doneCnt), LW'(2));
    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
